// File: rtl/divider_pkg.sv
// Shared RV32M divide-operation encodings and a small sign helper used by the divider.
package divider_pkg;

  localparam int DIV_OP_WIDTH = 2;

  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'b11;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divider.sv
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module divider
  import divider_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    div_valid,
  input  logic [DIV_OP_WIDTH-1:0] DIVop,
  input  logic [31:0]             dividend,
  input  logic [31:0]             divisor,
  output logic [31:0]             div_result,
  output logic                    div_ready,
  output logic                    div_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] divisor_abs;
  logic        is_rem;
  logic        neg_q;
  logic        neg_r;

  logic        op_signed;
  logic        op_rem;
  logic        div_by_zero;
  logic        overflow;
  logic [31:0] special_result;

  logic [32:0] r_shift;
  logic [31:0] q_shift;
  logic [31:0] r_next;
  logic [31:0] q_next;

  always_comb begin
    op_signed   = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
    op_rem      = (DIVop == DIV_OP_REM) || (DIVop == DIV_OP_REMU);
    div_by_zero = (divisor == '0);
    overflow    = op_signed && (dividend == 32'h8000_0000) && (divisor == '1);
    if (div_by_zero)
      special_result = op_rem ? dividend : '1;
    else
      special_result = op_rem ? '0 : 32'h8000_0000;
  end

  // The remainder after a successful subtract is below the divisor, so 32-bit
  // modular subtraction yields the exact result; bit 32 only feeds the compare.
  always_comb begin
    r_shift = {r, q[31]};
    q_shift = {q[30:0], 1'b0};
    r_next  = r_shift[31:0];
    q_next  = q_shift;
    if (r_shift >= {1'b0, divisor_abs}) begin
      r_next = r_shift[31:0] - divisor_abs;
      q_next = q_shift | 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      count       <= '0;
      q           <= '0;
      r           <= '0;
      divisor_abs <= '0;
      is_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_result  <= '0;
      div_ready   <= 1'b0;
      div_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_ready <= 1'b0;
          if (div_valid) begin
            div_busy <= 1'b1;
            if (div_by_zero || overflow) begin
              div_result <= special_result;
              div_ready  <= 1'b1;
              state      <= DONE;
            end else begin
              q           <= cond_neg(dividend, op_signed & dividend[31]);
              r           <= '0;
              divisor_abs <= cond_neg(divisor, op_signed & divisor[31]);
              is_rem      <= op_rem;
              neg_q       <= op_signed & (dividend[31] ^ divisor[31]);
              neg_r       <= op_signed & dividend[31];
              count       <= 5'd31;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          q     <= q_next;
          r     <= r_next;
          count <= count - 5'd1;
          if (count == '0) begin
            div_result <= is_rem ? cond_neg(r_next, neg_r) : cond_neg(q_next, neg_q);
            div_ready  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          div_ready <= 1'b0;
          div_busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
